// File: rtl/d_egress_arbiter_if.sv
// Output stream of the egress arbiter: head word, its destination tag and a
// valid/ready handshake.
interface d_egress_arbiter_if #(
    parameter int data_width = 6
);
    logic                  valid_out;
    logic                  out_ready;
    logic [data_width-1:0] data_out;
    logic                  dest_out;

    modport master (output valid_out, output data_out, output dest_out, input out_ready);
    modport slave  (input valid_out, input data_out, input dest_out, output out_ready);
endinterface

// File: rtl/d_egress_arbiter.sv
// Round-robin drain of the two destination FIFOs into one tagged output stream,
// with a 2-entry skid buffer covering the FIFO read latency and delivery counters.
module d_egress_arbiter #(
    parameter int data_width  = 6,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active_in,
    input  logic                   empty_fifo_D0,
    input  logic                   empty_fifo_D1,
    input  logic [data_width-1:0]  data_out_D0,
    input  logic [data_width-1:0]  data_out_D1,
    output logic                   D0_pop,
    output logic                   D1_pop,
    d_egress_arbiter_if.master     out_if,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1
);

    logic [1:0]             occ_reg;
    logic                   pending_reg;
    logic                   pending_dest_reg;
    logic                   last_reg;
    logic [data_width-1:0]  buf_data_reg  [2];
    logic                   buf_dest_reg  [2];
    logic [data_width-1:0]  buf_data_next [2];
    logic                   buf_dest_next [2];
    logic [count_width-1:0] count_reg     [2];
    logic [count_width-1:0] count_next    [2];

    logic                  consume;
    logic [1:0]            fill;
    logic                  has0;
    logic                  has1;
    logic                  sel;
    logic                  pop_any;
    logic                  tail_idx;
    logic [data_width-1:0] capture_data;

    assign out_if.valid_out = (occ_reg != 2'd0);
    assign out_if.data_out  = buf_data_reg[0];
    assign out_if.dest_out  = buf_dest_reg[0];
    assign count_D0         = count_reg[0];
    assign count_D1         = count_reg[1];

    assign consume = out_if.valid_out && out_if.out_ready;

    // Occupancy once the in-flight word lands and this cycle's consume leaves;
    // a new pop is only allowed if that still leaves a free slot.
    assign fill    = occ_reg + {1'b0, pending_reg} - {1'b0, consume};
    assign has0    = !empty_fifo_D0;
    assign has1    = !empty_fifo_D1;
    assign sel     = (has0 && has1) ? ~last_reg : has1;
    assign pop_any = reset && active_in && (fill < 2'd2) && (has0 || has1);
    assign D0_pop  = pop_any && !sel;
    assign D1_pop  = pop_any && sel;

    // Landing slot is occ - consume, which is only ever 0 or 1 while a word is pending.
    assign tail_idx     = occ_reg[0] ^ consume;
    assign capture_data = pending_dest_reg ? data_out_D1 : data_out_D0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign buf_data_next[gi] = (pending_reg && tail_idx == 1'(gi)) ? capture_data :
                                       (consume && gi == 0)                ? buf_data_reg[1] :
                                                                             buf_data_reg[gi];
            assign buf_dest_next[gi] = (pending_reg && tail_idx == 1'(gi)) ? pending_dest_reg :
                                       (consume && gi == 0)                ? buf_dest_reg[1] :
                                                                             buf_dest_reg[gi];
            assign count_next[gi]    = (consume && buf_dest_reg[0] == 1'(gi)) ?
                                       count_reg[gi] + count_width'(1) : count_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_reg          <= 2'd0;
            pending_reg      <= 1'b0;
            pending_dest_reg <= 1'b0;
            last_reg         <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                buf_data_reg[i] <= '0;
                buf_dest_reg[i] <= 1'b0;
                count_reg[i]    <= '0;
            end
        end else begin
            occ_reg     <= fill;
            pending_reg <= pop_any;
            if (pop_any) begin
                pending_dest_reg <= sel;
                last_reg         <= sel;
            end
            for (int i = 0; i < 2; i++) begin
                buf_data_reg[i] <= buf_data_next[i];
                buf_dest_reg[i] <= buf_dest_next[i];
                count_reg[i]    <= count_next[i];
            end
        end
    end

endmodule

// File: tb/tb_d_egress_arbiter.sv
// Bench for d_egress_arbiter: queue-based FIFO emulation, a per-cycle reference
// model of the skid buffer and round-robin, plus directed literal checks.
module tb_d_egress_arbiter;
    localparam int DW = 6;
    localparam int CW = 8;

    typedef struct packed {
        logic          dest;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic          dest;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } log_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          active_in = 1'b0;
    logic          empty_fifo_D0 = 1'b1;
    logic          empty_fifo_D1 = 1'b1;
    logic [DW-1:0] data_out_D0 = '0;
    logic [DW-1:0] data_out_D1 = '0;
    logic          D0_pop;
    logic          D1_pop;
    logic [CW-1:0] count_D0;
    logic [CW-1:0] count_D1;

    d_egress_arbiter_if #(.data_width(DW)) out_if ();

    d_egress_arbiter #(.data_width(DW), .count_width(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .active_in     (active_in),
        .empty_fifo_D0 (empty_fifo_D0),
        .empty_fifo_D1 (empty_fifo_D1),
        .data_out_D0   (data_out_D0),
        .data_out_D1   (data_out_D1),
        .D0_pop        (D0_pop),
        .D1_pop        (D1_pop),
        .out_if        (out_if),
        .count_D0      (count_D0),
        .count_D1      (count_D1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    int n_pop0 = 0;
    int n_pop1 = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    log_t          dlog[$];

    word_t         mbuf[$];
    logic          mpend;
    logic          mlast;
    word_t         mpend_w;
    logic [CW-1:0] mcnt0;
    logic [CW-1:0] mcnt1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mbuf.delete();
        mpend   = 1'b0;
        mlast   = 1'b1;
        mpend_w = '0;
        mcnt0   = '0;
        mcnt1   = '0;
    endtask

    // Reference model, FIFO emulation and the per-cycle compare.
    initial begin
        logic  e_pop0, e_pop1, e_cons, e_sel, e_any, s_pop0, s_pop1, ne0, ne1;
        int    fill;
        word_t head;
        log_t  ent;
        model_clear();
        forever begin
            @(negedge clk);
            if (!reset) model_clear();
            e_cons = (mbuf.size() != 0) && out_if.out_ready;
            ne0    = (q0.size() != 0);
            ne1    = (q1.size() != 0);
            fill   = mbuf.size() + int'(mpend) - int'(e_cons);
            e_any  = reset && active_in && (fill < 2) && (ne0 || ne1);
            e_sel  = (ne0 && ne1) ? !mlast : ne1;
            e_pop0 = e_any && !e_sel;
            e_pop1 = e_any && e_sel;
            check("pops", {D1_pop, D0_pop}, {e_pop1, e_pop0});
            check("valid_out", out_if.valid_out, mbuf.size() != 0);
            if (mbuf.size() != 0) begin
                head = mbuf[0];
                check("head_word", {out_if.dest_out, out_if.data_out}, head);
            end
            check("count_D0", count_D0, mcnt0);
            check("count_D1", count_D1, mcnt1);
            s_pop0 = D0_pop;
            s_pop1 = D1_pop;
            if (s_pop0) n_pop0++;
            if (s_pop1) n_pop1++;
            if (out_if.valid_out && out_if.out_ready) begin
                ent.dest = out_if.dest_out;
                ent.data = out_if.data_out;
                ent.cyc  = cyc;
                dlog.push_back(ent);
            end

            @(posedge clk);
            cyc++;
            if (reset) begin
                if (e_cons) begin
                    head = mbuf.pop_front();
                    if (head.dest) mcnt1++;
                    else mcnt0++;
                end
                if (mpend) mbuf.push_back(mpend_w);
                mpend = e_any;
                if (e_any) begin
                    mlast   = e_sel;
                    mpend_w = e_sel ? {1'b1, q1[0]} : {1'b0, q0[0]};
                end
            end else begin
                model_clear();
            end

            #2;
            if (s_pop0 && q0.size() != 0) data_out_D0 = q0.pop_front();
            else data_out_D0 = DW'($urandom);
            if (s_pop1 && q1.size() != 0) data_out_D1 = q1.pop_front();
            else data_out_D1 = DW'($urandom);
            empty_fifo_D0 = (q0.size() == 0);
            empty_fifo_D1 = (q1.size() == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (dlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("log_len", dlog.size(), n);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_valid", out_if.valid_out, 0);
        check("rst_data", {out_if.dest_out, out_if.data_out}, 0);
        check("rst_pops", {D1_pop, D0_pop}, 0);
        check("rst_cnt0", count_D0, 0);
        check("rst_cnt1", count_D1, 0);
        q0.delete();
        q1.delete();
        repeat (hold) @(posedge clk);
        #3;
        reset = 1'b1;
        dlog.delete();
        n_pop0 = 0;
        n_pop1 = 0;
        tick();
    endtask

    initial begin
        int c0;
        out_if.out_ready = 1'b0;

        // Reset then idle.
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (4) tick();
        check("idle_valid", out_if.valid_out, 0);
        check("idle_pops", n_pop0 + n_pop1, 0);
        check("idle_cnt", {count_D1, count_D0}, 0);

        // Single D0 word: two-cycle latency from pop to valid.
        active_in = 1'b1;
        out_if.out_ready = 1'b1;
        q0.push_back(6'b010000);
        c0 = cyc;
        wait_log(1, 10);
        repeat (2) tick();
        check("single_pops", n_pop0, 1);
        if (dlog.size() != 0) begin
            check("single_lat", dlog[0].cyc - c0, 2);
            check("single_word", {dlog[0].dest, dlog[0].data}, {1'b0, 6'b010000});
        end
        check("single_cnt", count_D0, 1);

        // Both FIFOs hold 4 words: strict alternation starting with D0.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(DW'(6'h01 + i));
            q1.push_back(DW'(6'h11 + i));
        end
        wait_log(8, 40);
        tick();
        if (dlog.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check("alt_word", {dlog[i].dest, dlog[i].data},
                      {1'(i % 2), (i % 2 == 1) ? DW'(6'h11 + i / 2) : DW'(6'h01 + i / 2)});
            check("alt_burst", dlog[7].cyc - dlog[0].cyc, 7);
        end
        check("alt_cnt0", count_D0, 4);
        check("alt_cnt1", count_D1, 4);

        // Backpressure: only 2 pops while blocked, head held, then in-order drain.
        do_reset(2);
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) q1.push_back(DW'(6'h20 + i));
        repeat (5) tick();
        check("bp_pops", n_pop1, 2);
        check("bp_head", {out_if.valid_out, out_if.dest_out, out_if.data_out}, {2'b11, 6'h20});
        out_if.out_ready = 1'b1;
        wait_log(6, 40);
        if (dlog.size() == 6)
            for (int i = 0; i < 6; i++)
                check("bp_word", {dlog[i].dest, dlog[i].data}, {1'b1, DW'(6'h20 + i)});
        check("bp_total", n_pop1, 6);

        // active_in drops right after a pop: that word still arrives, pops pause.
        do_reset(2);
        for (int i = 0; i < 3; i++) q0.push_back(DW'(6'h30 + i));
        tick();
        active_in = 1'b0;
        repeat (6) tick();
        check("act_pops", n_pop0, 1);
        check("act_len", dlog.size(), 1);
        if (dlog.size() != 0) check("act_word", dlog[0].data, 6'h30);
        active_in = 1'b1;
        wait_log(3, 30);
        check("act_resume", n_pop0, 3);
        if (dlog.size() == 3) check("act_last", dlog[2].data, 6'h32);

        // 256 D0 words under random backpressure: counter wraps to 0.
        do_reset(2);
        for (int i = 0; i < 256; i++) q0.push_back(DW'($urandom));
        begin
            int k = 0;
            while (dlog.size() < 256 && k < 2000) begin
                out_if.out_ready = ($urandom_range(0, 3) != 0);
                tick();
                k++;
            end
        end
        check("wrap_len", dlog.size(), 256);
        check("wrap_cnt0", count_D0, 0);

        // Asynchronous reset mid-stream.
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        repeat (3) tick();
        check("mid_valid", out_if.valid_out, 1);
        do_reset(1);

        // Random traffic with occasional resets.
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(DW'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
            active_in = ($urandom_range(0, 7) != 0);
            out_if.out_ready = ($urandom_range(0, 3) != 0);
            if (it % 700 == 699) do_reset(1 + (it % 3));
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/d_egress_arbiter.md
# d_egress_arbiter

Drains the two destination FIFOs (D0, D1) at the output of `full_logic` into a single output stream. It issues `D0_pop`/`D1_pop` round-robin, absorbs the FIFOs' one-cycle read latency with a 2-entry skid buffer, and presents each word with its destination tag under a valid/ready handshake. It also keeps per-destination delivered-word counters. It pops only while the upstream state machine reports active.

## Interface
Parameters:
- `data_width`, 6, word width of D FIFO data and of `data_out`
- `count_width`, 8, width of the delivered-word counters

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low; state cleared immediately while low
- `active_in`  in  1  `active_out` of `full_logic`; new pops are allowed only while high
- `empty_fifo_D0`, `empty_fifo_D1`  in  1 each  D FIFO empty flags
- `data_out_D0`, `data_out_D1`  in  `data_width` each  D FIFO read data, valid the cycle after a pop
- `D0_pop`, `D1_pop`  out  1 each  combinational pop strobes, at most one high per cycle
- `out_ready`  in  1  downstream accepts the head word this cycle
- `valid_out`  out  1  head word valid
- `data_out`  out  `data_width`  head word
- `dest_out`  out  1  source of the head word: 0=D0, 1=D1
- `count_D0`, `count_D1`  out  `count_width` each  words delivered per destination; wrap modulo 2^count_width

## Operation
- Skid buffer: 2 entries, FIFO order, each entry holds {data, dest}. `occ` ranges 0..2. The head drives `data_out`/`dest_out`. `valid_out` = (`occ` != 0).
- Handshake: a word is consumed when `valid_out` && `out_ready`. The head then advances at the clock edge.
- `pending` (1 bit, plus `pending_dest`) marks a pop issued the previous cycle. While it is set, `data_out_D{pending_dest}` is valid and is written into the buffer tail at this edge.
- Pop is allowed when all of these hold:
  - `active_in` = 1
  - the selected FIFO is not empty
  - `occ` + `pending` − (consume this cycle) < 2

  This rule means the buffer can never overflow.
- Round-robin: pointer `last` = destination of the last pop.
  - If both FIFOs are non-empty, pop the one != `last`.
  - If only one is non-empty, pop that one.
  - `last` updates only on an actual pop.
  - After reset `last`=1, so D0 wins the first tie.
- Simultaneous capture and consume in one cycle: `occ` stays unchanged and the FIFO order is preserved.
- If `active_in` falls with a pop pending, the pending word is still captured and the buffer still drains. No new pops are issued until `active_in` rises again.
- Counters: `count_D{dest_out}` increments by 1 on each consume. Both counters wrap 2^count_width−1 → 0.
- A pop is never issued to an empty FIFO; the empty flag gates the strobe combinationally.

## Timing
- Reset low forces these values asynchronously:
  - `occ`=0, `pending`=0, `last`=1
  - `valid_out`=0, `data_out`=0, `dest_out`=0, `count_D0`=`count_D1`=0
  - `D0_pop`=`D1_pop`=0, because `active_in` is masked while reset is low
- Latency: pop in cycle N; word captured at the end of N+1; `valid_out`=1 in N+2, when the buffer was empty.
- Throughput: one word per cycle sustained while `out_ready`=1 and any FIFO is non-empty.
- Backpressure: with `out_ready` held 0, at most 2 words are fetched (including the in-flight pop), then pops stop. `data_out`/`dest_out` remain stable while `valid_out`=1 and `out_ready`=0.
- Reset asserted mid-flight discards buffer contents and any pending pop. The FIFO word already popped is lost; this is accepted.

## Test plan
- Reset then idle: `reset`=0 for 3 cycles, then `reset`=1 with both FIFOs empty → all outputs 0, no pops, counters 0.
- Single D0 word 6'b010000, `active_in`=1, `out_ready`=1 → `D0_pop` high 1 cycle; 2 cycles later `valid_out`=1, `data_out`=6'b010000, `dest_out`=0; `count_D0`=1.
- Both FIFOs hold 4 words → pops alternate D0,D1,D0,D1,…; output has 8 consecutive valid cycles with alternating `dest_out`; `count_D0`=`count_D1`=4.
- `out_ready`=0 for 5 cycles with D1 holding 6 words → exactly 2 `D1_pop` strobes, then none; head word stable. On `out_ready`=1, all 6 words delivered in order.
- `active_in` dropped in the cycle after a pop → that word is delivered, no further pops; pops resume on re-assert.
- 256 D0 words delivered → `count_D0` wraps to 0. Async `reset` pulse mid-stream → `valid_out`=0 immediately, counters 0.
